// File: rtl/lock_attempt_controller.sv
// Sequences unlock attempts between the raw ENTER button and the lock FSM:
// debounces the button, judges attempts made while locked, counts
// consecutive failures and enforces an exponentially growing lockout.
//
// No handshake on this block: enter_out is a plain level. It rises in the
// same cycle the debounced level rises and falls in the same cycle it falls,
// while lockout_active, fail_count, lockout_level and alarm are stable
// register values that change only on clk edges.
module lock_attempt_controller #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int MAX_FAILS       = 3,
    parameter int LOCKOUT_CYCLES  = 50_000_000,
    parameter int MAX_LEVEL       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enter_raw,
    input  logic       locked,
    input  logic       match,
    output logic       enter_out,
    output logic       lockout_active,
    output logic [3:0] fail_count,
    output logic [1:0] lockout_level,
    output logic       alarm,
    output logic [2:0] state_dbg
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int TIMER_W = $clog2(LOCKOUT_CYCLES << MAX_LEVEL) + 1;

    localparam logic [DB_W-1:0]    DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_BASE = TIMER_W'(LOCKOUT_CYCLES);
    localparam logic [3:0]         FAIL_LAST    = 4'(MAX_FAILS - 1);
    localparam logic [1:0]         LEVEL_MAX    = 2'(MAX_LEVEL);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESSED      = 3'd1,
        EVAL         = 3'd2,
        LOCKOUT      = 3'd3,
        WAIT_RELEASE = 3'd4
    } state_t;

    state_t              state;
    logic                db;
    logic [DB_W-1:0]     db_cnt;
    logic                db_toggle;
    logic                db_rise;
    logic                attempt;
    logic [TIMER_W-1:0]  timer;

    // db flips on the edge where the counter has already seen DEBOUNCE_CYCLES-1
    // disagreeing cycles, so the FSM can act on the rise in that same edge.
    assign db_toggle = (enter_raw != db) && (db_cnt == DB_LAST);
    assign db_rise   = db_toggle && !db;

    // Debounce: count consecutive cycles where the raw button disagrees with db.
    always_ff @(posedge clk) begin
        if (reset) begin
            db     <= 1'b0;
            db_cnt <= '0;
        end else if (enter_raw == db) begin
            db_cnt <= '0;
        end else if (db_toggle) begin
            db     <= ~db;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Attempt sequencer: press tracking, evaluation, failure counting, backoff.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            attempt       <= 1'b0;
            timer         <= '0;
            fail_count    <= '0;
            lockout_level <= '0;
            alarm         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (db_rise) begin
                        attempt <= locked;
                        state   <= PRESSED;
                    end
                end
                PRESSED: begin
                    // The press-time attempt flag decides, not the current locked.
                    if (!db) state <= attempt ? EVAL : IDLE;
                end
                EVAL: begin
                    if (match) begin
                        fail_count    <= '0;
                        lockout_level <= '0;
                        alarm         <= 1'b0;
                        state         <= IDLE;
                    end else if (fail_count == FAIL_LAST) begin
                        // Length uses the level in force before this lockout.
                        timer      <= (LOCKOUT_BASE << lockout_level) - TIMER_W'(1);
                        fail_count <= '0;
                        if (lockout_level == LEVEL_MAX) alarm <= 1'b1;
                        else lockout_level <= lockout_level + 2'd1;
                        state      <= LOCKOUT;
                    end else begin
                        fail_count <= fail_count + 4'd1;
                        state      <= IDLE;
                    end
                end
                LOCKOUT: begin
                    if (timer == '0) state <= db ? WAIT_RELEASE : IDLE;
                    else timer <= timer - TIMER_W'(1);
                end
                WAIT_RELEASE: begin
                    // A press held across the lockout end must be released first.
                    if (!db) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output decode: enter_out falls combinationally with db.
    assign enter_out      = (state == PRESSED) && db;
    assign lockout_active = (state == LOCKOUT);
    assign state_dbg      = state;

endmodule

// File: doc/lock_attempt_controller.md
Name: lock_attempt_controller

Overview:
- Sits between the raw ENTER button and the combination-lock state machine, and sequences every unlock attempt.
- Debounces the button and forwards a clean ENTER level to the lock FSM.
- Judges each attempt made while locked and counts consecutive failures.
- After MAX_FAILS failures it blocks ENTER for a lockout period that doubles on each repeat lockout, and raises a sticky alarm when the backoff saturates.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles needed before the debounced level changes (20 ms at 50 MHz).
- MAX_FAILS, 3: consecutive failed attempts that trigger a lockout; range 1..15.
- LOCKOUT_CYCLES, 50_000_000: base lockout length in cycles, at level 0.
- MAX_LEVEL, 3: highest backoff level. Lockout length is LOCKOUT_CYCLES << level.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- enter_raw, input, 1: ENTER button, active-high, undebounced.
- locked, input, 1: isLocked from the lock FSM.
- match, input, 1: attempt == password, from the datapath.
- enter_out, input/output: output, 1: debounced, gated ENTER level to the lock FSM.
- lockout_active, output, 1: high while a lockout timer is running.
- fail_count, output, 4: consecutive failures since the last success or lockout.
- lockout_level, output, 2: current backoff level, 0..MAX_LEVEL.
- alarm, output, 1: sticky; set when a lockout fires while already at MAX_LEVEL.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset, sampled only at posedge clk.
- Reset values: all outputs are 0, the debounced level is 0, the timers are 0, and the FSM is in IDLE.
- Reset mid-lockout or mid-press returns to IDLE immediately; no pending evaluation survives.
- Debounce:
  - A counter counts cycles in which enter_raw differs from the debounced level db.
  - Any cycle where they agree clears the counter.
  - When the counter reaches DEBOUNCE_CYCLES-1, db toggles on the next edge. Latency from a stable input change to db is DEBOUNCE_CYCLES cycles.
- FSM states: IDLE, PRESSED, EVAL, LOCKOUT, WAIT_RELEASE.
- IDLE:
  - enter_out = 0.
  - On a rising edge of db: if locked=1, latch an "attempt" flag, otherwise clear it; then go to PRESSED.
- PRESSED:
  - enter_out = 1.
  - When db falls, go to EVAL if the attempt flag is 1, else to IDLE.
  - enter_out drops in the same cycle db drops, which is combinational from db.
- EVAL:
  - Lasts exactly one cycle, the first cycle after release; match is sampled in this cycle. enter_out = 0.
  - match=1: clear fail_count, lockout_level and alarm; go to IDLE.
  - match=0 and fail_count+1 < MAX_FAILS: increment fail_count; go to IDLE.
  - match=0 and fail_count+1 == MAX_FAILS:
    - Load the timer with (LOCKOUT_CYCLES << lockout_level) - 1 and clear fail_count.
    - If lockout_level == MAX_LEVEL, set alarm; otherwise increment lockout_level, which saturates and never wraps.
    - Go to LOCKOUT.
- LOCKOUT:
  - lockout_active = 1 and enter_out = 0 regardless of db.
  - The timer decrements each cycle.
  - When the timer is 0: if db = 1, go to WAIT_RELEASE, else go to IDLE.
  - Total lockout_active high time is exactly LOCKOUT_CYCLES << level_at_entry cycles.
- WAIT_RELEASE:
  - enter_out = 0 and lockout_active = 0.
  - Go to IDLE when db = 0. A press held across the end of a lockout is never forwarded.
- Presses while unlocked (locked=0 at the rising edge of db) are passed through for password setting. They are never evaluated and do not change the counters.
- If locked changes during PRESSED, it is ignored; the attempt flag latched at press time decides.
- Timer width is clog2((LOCKOUT_CYCLES << MAX_LEVEL)) + 1 bits. There is no overflow at MAX_LEVEL.
- fail_count never exceeds MAX_FAILS-1 when observed outside EVAL.

Test Plan (bench params: DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=20, MAX_FAILS=3, MAX_LEVEL=3):
- Bounce: enter_raw toggles every 2 cycles for 20 cycles, then held at 1 → enter_out rises exactly 4 cycles after the final 0→1 and never glitches before.
- Locked, one press with match=1 → EVAL fires 1 cycle after enter_out falls; fail_count stays 0, lockout_level 0.
- Locked, 3 presses with match=0 → fail_count reads 1, then 2, then 0. lockout_active is high for exactly 20 cycles and lockout_level becomes 1.
  - A press during the lockout → enter_out stays 0.
- Four consecutive lockouts, 3 failures each → lockout durations are 20, 40, 80 and 160 cycles. alarm is set at the 4th lockout and lockout_level stays 3.
  - A subsequent match=1 attempt clears alarm and lockout_level.
- Button held through the end of a lockout → the FSM goes to WAIT_RELEASE with enter_out 0. After release and a fresh press, enter_out rises 4 cycles after the press.
- Unlocked (locked=0) presses ×5 with match=0 → enter_out is forwarded each time; fail_count stays 0.
- reset pulsed mid-LOCKOUT at timer=7 → on the next cycle all outputs are 0, and an immediate press is forwarded after 4 cycles.
